sprite_layer: RTL and testbench

SPRITE_LAYER -- requirements
Module: sprite_layer

---
 rtl/sprite_layer_if.sv | 29 ++
 rtl/sprite_layer.sv | 112 +++++++++++
 tb/tb_sprite_layer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sprite_layer_if.sv
// Pixel-stream, configuration and sprite-ROM signals of the sprite layer.
// master: video timing/CPU/ROM side; slave: the sprite_layer block.
interface sprite_layer_if;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        frame_start;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [11:0] rom_addr;
  logic [23:0] rom_rdata;
  logic [23:0] layer_pixel;
  logic        layer_valid;

  modport master (
    output pix_valid, pix_x, pix_y, frame_start,
    output cfg_we, cfg_addr, cfg_wdata,
    output rom_rdata,
    input  rom_addr, layer_pixel, layer_valid
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, frame_start,
    input  cfg_we, cfg_addr, cfg_wdata,
    input  rom_rdata,
    output rom_addr, layer_pixel, layer_valid
  );
endinterface

// File: rtl/sprite_layer.sv
// Single hardware sprite: double-buffered config, hit test, ROM fetch, RGB888 out.
// Latency 3 cycles pix_valid -> layer_valid; one sample per cycle, no backpressure.
module sprite_layer #(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  sprite_layer_if.slave bus
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  typedef struct packed {
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        vflip;
    logic        hflip;
    logic        en;
    logic [11:0] base;
  } cfg_t;

  cfg_t pend_q;
  cfg_t act_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else if (bus.cfg_we) begin
      case (bus.cfg_addr)
        2'd0: pend_q.pos_x <= bus.cfg_wdata[9:0];
        2'd1: pend_q.pos_y <= bus.cfg_wdata[9:0];
        2'd2: {pend_q.vflip, pend_q.hflip, pend_q.en} <= bus.cfg_wdata[2:0];
        default: pend_q.base <= bus.cfg_wdata[11:0];
      endcase
    end
  end

  // Active bank samples pending before this edge's write lands, so a
  // coincident write waits for the following frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= '0;
    end else if (bus.frame_start) begin
      act_q <= pend_q;
    end
  end

  logic [10:0]   x_end;
  logic [10:0]   y_end;
  logic          in_x;
  logic          in_y;
  logic          hit_s0;
  logic [9:0]    off_x;
  logic [9:0]    off_y;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [11:0]   addr_s0;

  // 11-bit ends so a sprite near 1023 clips instead of wrapping to column 0.
  always_comb begin
    x_end   = {1'b0, act_q.pos_x} + 11'(SPR_W);
    y_end   = {1'b0, act_q.pos_y} + 11'(SPR_H);
    in_x    = (bus.pix_x >= act_q.pos_x) && ({1'b0, bus.pix_x} < x_end);
    in_y    = (bus.pix_y >= act_q.pos_y) && ({1'b0, bus.pix_y} < y_end);
    hit_s0  = bus.pix_valid && act_q.en && in_x && in_y;
    off_x   = bus.pix_x - act_q.pos_x;
    off_y   = bus.pix_y - act_q.pos_y;
    col     = act_q.hflip ? ~off_x[CW-1:0] : off_x[CW-1:0];
    row     = act_q.vflip ? ~off_y[RW-1:0] : off_y[RW-1:0];
    addr_s0 = act_q.base + 12'({row, col});
  end

  logic [11:0] rom_addr_q;
  logic        vld0_q;
  logic        hit0_q;
  logic        vld1_q;
  logic        hit1_q;
  logic [23:0] layer_pixel_q;
  logic        layer_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q    <= '0;
      vld0_q        <= 1'b0;
      hit0_q        <= 1'b0;
      vld1_q        <= 1'b0;
      hit1_q        <= 1'b0;
      layer_pixel_q <= '0;
      layer_valid_q <= 1'b0;
    end else begin
      if (bus.pix_valid) begin
        rom_addr_q <= addr_s0;
      end
      vld0_q        <= bus.pix_valid;
      hit0_q        <= hit_s0;
      vld1_q        <= vld0_q;
      hit1_q        <= hit0_q;
      layer_pixel_q <= hit1_q ? bus.rom_rdata : 24'h000000;
      layer_valid_q <= vld1_q;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.layer_pixel = layer_pixel_q;
  assign bus.layer_valid = layer_valid_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.cfg_wdata[15:12], off_x[9:CW], off_y[9:RW]};

endmodule

// File: tb/tb_sprite_layer.sv
// Directed table-driven bench for sprite_layer with a behavioural synchronous ROM.
module tb_sprite_layer;

  logic clk;
  logic rst_n;
  sprite_layer_if bus();

  sprite_layer #(.SPR_W(16), .SPR_H(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] rom [0:4095];
  always @(posedge clk) bus.rom_rdata <= rom[bus.rom_addr];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic frame_pulse();
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic apply_sample(input string name, input logic [9:0] x, input logic [9:0] y,
                              input logic ca, input logic [11:0] ea, input logic [23:0] ep);
    @(negedge clk);
    bus.pix_valid = 1'b1; bus.pix_x = x; bus.pix_y = y;
    @(posedge clk);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    if (ca) chk({name, "_addr"}, 24'(bus.rom_addr), 24'(ea));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_vld"}, 24'(bus.layer_valid), 24'd1);
    chk({name, "_pix"}, bus.layer_pixel, ep);
  endtask

  typedef struct {
    logic [9:0]  px, py;
    logic [2:0]  ctrl;
    logic [11:0] base;
    logic [9:0]  x, y;
    logic        ca;
    logic [11:0] ea;
    logic [23:0] ep;
  } vec_t;

  vec_t vt [14];

  // Stream sequence: valid, x, y, frame_start, expected valid, expected pixel
  logic        sv  [6] = '{1, 1, 0, 1, 1, 1};
  logic [9:0]  sx  [6] = '{200, 201, 200, 202, 202, 5};
  logic [9:0]  sy  [6] = '{50, 50, 50, 51, 51, 50};
  logic        sfs [6] = '{0, 0, 0, 1, 0, 0};
  logic [23:0] sp  [6] = '{24'hFF0000, 24'h001FFE, 24'h0, 24'h012FED, 24'h0, 24'h005FFA};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = {i[11:0], ~i[11:0]};
    rom[0]  = 24'hFF0000;
    rom[17] = 24'h000000;

    //        px    py  ctrl base  x     y   ca  ea    ep
    vt[0]  = '{100, 50, 1, 0,   100,  50, 1, 0,   24'hFF0000};
    vt[1]  = '{100, 50, 1, 0,   99,   50, 0, 0,   24'h000000};
    vt[2]  = '{100, 50, 1, 0,   116,  50, 0, 0,   24'h000000};
    vt[3]  = '{100, 50, 1, 0,   100,  66, 0, 0,   24'h000000};
    vt[4]  = '{100, 50, 1, 0,   115,  65, 1, 255, 24'h0FFF00};
    vt[5]  = '{100, 50, 1, 0,   101,  51, 1, 17,  24'h000000};
    vt[6]  = '{100, 50, 1, 0,   100,  49, 0, 0,   24'h000000};
    vt[7]  = '{100, 50, 7, 256, 100,  50, 1, 511, 24'h1FFE00};
    vt[8]  = '{100, 50, 7, 256, 115,  65, 1, 256, 24'h100EFF};
    vt[9]  = '{100, 50, 7, 256, 103,  52, 1, 476, 24'h1DCE23};
    vt[10] = '{1020, 50, 1, 0,  1023, 50, 1, 3,   24'h003FFC};
    vt[11] = '{1020, 50, 1, 0,  0,    50, 0, 0,   24'h000000};
    vt[12] = '{1020, 50, 1, 0,  1020, 60, 1, 160, 24'h0A0F5F};
    vt[13] = '{1020, 50, 1, 0,  1023, 65, 1, 243, 24'h0F3F0C};

    rst_n = 1'b0;
    bus.pix_valid = 1'b0; bus.pix_x = '0; bus.pix_y = '0;
    bus.frame_start = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_rom_addr", 24'(bus.rom_addr), 24'd0);
    chk("rst_pixel", bus.layer_pixel, 24'd0);
    chk("rst_valid", 24'(bus.layer_valid), 24'd0);
    rst_n = 1'b1;

    // Reset config: disabled, so (0,0) over ROM[0]=FF0000 stays transparent.
    apply_sample("rst_disabled", 0, 0, 0, 0, 24'h000000);

    for (int i = 0; i < 14; i++) begin
      if (i == 0 || vt[i].px != vt[i-1].px || vt[i].py != vt[i-1].py ||
          vt[i].ctrl != vt[i-1].ctrl || vt[i].base != vt[i-1].base) begin
        cfg_write(2'd0, 16'(vt[i].px));
        cfg_write(2'd1, 16'(vt[i].py));
        cfg_write(2'd2, 16'(vt[i].ctrl));
        cfg_write(2'd3, 16'(vt[i].base));
        frame_pulse();
      end
      apply_sample($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].ca, vt[i].ea, vt[i].ep);
    end

    // Active pos_x is 1020; a pending-only write must not move the sprite.
    cfg_write(2'd0, 16'd100);
    apply_sample("pend_only", 100, 50, 0, 0, 24'h000000);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_wdata = 16'd200; bus.frame_start = 1'b1;
    @(negedge clk);
    bus.cfg_we = 1'b0; bus.frame_start = 1'b0;
    apply_sample("coinc_old_hit", 100, 50, 1, 0, 24'hFF0000);
    apply_sample("coinc_new_miss", 200, 50, 0, 0, 24'h000000);
    frame_pulse();
    apply_sample("next_new_hit", 200, 50, 1, 0, 24'hFF0000);
    apply_sample("next_old_miss", 100, 50, 0, 0, 24'h000000);

    // Back-to-back stream with a bubble and a mid-line frame_start moving pos_x to 0.
    cfg_write(2'd0, 16'd0);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        chk($sformatf("stream%0d_vld", c - 3), 24'(bus.layer_valid), 24'(sv[c-3]));
        chk($sformatf("stream%0d_pix", c - 3), bus.layer_pixel, sp[c-3]);
      end
      if (c < 6) begin
        bus.pix_valid = sv[c]; bus.pix_x = sx[c]; bus.pix_y = sy[c]; bus.frame_start = sfs[c];
      end else begin
        bus.pix_valid = 1'b0; bus.frame_start = 1'b0;
      end
    end

    // Continuous stream at (5,50), then a one-cycle reset pulse.
    @(negedge clk);
    bus.pix_valid = 1'b1; bus.pix_x = 10'd5; bus.pix_y = 10'd50;
    repeat (4) @(negedge clk);
    chk("pre_rst_pix", bus.layer_pixel, 24'h005FFA);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", 24'(bus.rom_addr), 24'd0);
    chk("mid_rst_pix", bus.layer_pixel, 24'd0);
    chk("mid_rst_vld", 24'(bus.layer_valid), 24'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel1_vld", 24'(bus.layer_valid), 24'd0);
    @(negedge clk);
    chk("rel2_vld", 24'(bus.layer_valid), 24'd0);
    @(negedge clk);
    chk("rel3_vld", 24'(bus.layer_valid), 24'd1);
    chk("rel3_pix_disabled", bus.layer_pixel, 24'd0);
    bus.pix_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
